// File: rtl/explode_pkg.sv
// Shared definitions for the explode unload path: width helpers, arbiter FSM
// states and the round-robin index wrap used by the lane picker.
package explode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_e;

    function automatic int data_w(input int nonce_w, input int explode_w);
        return nonce_w + explode_w;
    endfunction

    function automatic int lane_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

    // Lane index `offset` places after `base`, wrapping at n_lanes without a
    // modulo so non-power-of-2 lane counts stay cheap.
    function automatic int wrap_idx(input int base, input int offset, input int n_lanes);
        int sum;
        sum = base + offset;
        return (sum >= n_lanes) ? (sum - n_lanes) : sum;
    endfunction

endpackage

// File: rtl/explode_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after i_ptr,
// wrapping from the last lane back to lane 0.
module explode_rr_pick
    import explode_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 2
) (
    input  logic [N_LANES-1:0] i_req,
    input  logic [LANE_W-1:0]  i_ptr,
    output logic [LANE_W-1:0]  o_grant,
    output logic               o_any
);

    // Scan from farthest to nearest so the nearest requester wins last.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // it unassigned and no latch is inferred.
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (i_req[LANE_W'(wrap_idx(int'(i_ptr), i, N_LANES))]) begin
                o_grant = LANE_W'(wrap_idx(int'(i_ptr), i, N_LANES));
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/explode_unload_arbiter.sv
// Round-robin arbiter sharing one valid/ready result port between N_LANES
// explode unloaders that each speak a 4-phase req/recv handshake.
module explode_unload_arbiter
    import explode_pkg::*;
#(
    parameter  int N_LANES       = 4,
    parameter  int NONCE_WIDTH   = 7,
    parameter  int EXPLODE_WIDTH = 512,
    localparam int DATA_W        = data_w(NONCE_WIDTH, EXPLODE_WIDTH),
    localparam int LANE_W        = lane_w(N_LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_LANES-1:0]        i_lane_handshake,
    input  logic [N_LANES*DATA_W-1:0] i_lane_data,
    output logic [N_LANES-1:0]        o_lane_handshake_recv,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [LANE_W-1:0]         o_lane_id,
    input  logic                      i_ready,
    output logic                      o_proto_err
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [N_LANES-1:0]  r_req_q;
    logic [LANE_W-1:0]   r_grant;
    logic [LANE_W-1:0]   r_rr_ptr;
    logic [N_LANES-1:0]  r_recv;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [LANE_W-1:0]   r_lane_id;
    logic                r_proto_err;

    logic [LANE_W-1:0]   w_grant_nxt;
    logic [LANE_W-1:0]   w_rr_ptr_nxt;
    logic [N_LANES-1:0]  w_recv_nxt;
    logic                w_valid_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [LANE_W-1:0]   w_lane_id_nxt;
    logic                w_proto_err_nxt;

    logic [LANE_W-1:0]   w_pick_grant;
    logic                w_pick_any;
    logic [DATA_W-1:0]   w_lane_data;
    logic                w_granted_req;
    logic [N_LANES-1:0]  w_grant_onehot;
    logic [LANE_W-1:0]   w_ptr_after_grant;

    explode_rr_pick #(
        .N_LANES (N_LANES),
        .LANE_W  (LANE_W)
    ) u_rr_pick (
        .i_req   (r_req_q),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_any   (w_pick_any)
    );

    // Constant-index mux keeps the data select free of variable part-selects.
    always_comb begin
        w_lane_data = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (r_grant == LANE_W'(k)) begin
                w_lane_data = i_lane_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_granted_req     = r_req_q[r_grant];
    assign w_grant_onehot    = N_LANES'(1) << r_grant;
    assign w_ptr_after_grant = (r_grant == LANE_W'(N_LANES - 1)) ? '0 : r_grant + LANE_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_recv_nxt      = r_recv;
        w_valid_nxt     = r_valid;
        w_data_nxt      = r_data;
        w_lane_id_nxt   = r_lane_id;
        w_proto_err_nxt = r_proto_err;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_grant;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The lane must still be requesting when its data is latched;
                // otherwise the grant is abandoned and the error is recorded.
                if (w_granted_req) begin
                    w_data_nxt    = w_lane_data;
                    w_lane_id_nxt = r_grant;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = ST_SEND;
                end else begin
                    w_proto_err_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!w_granted_req) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (r_valid && i_ready) begin
                    w_valid_nxt = 1'b0;
                    w_recv_nxt  = w_grant_onehot;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w_granted_req) begin
                    w_recv_nxt   = '0;
                    w_rr_ptr_nxt = w_ptr_after_grant;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values and updates together.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q     <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_recv      <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_lane_id   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_req_q     <= i_lane_handshake;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_recv      <= w_recv_nxt;
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_lane_id   <= w_lane_id_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign o_lane_handshake_recv = r_recv;
    assign o_valid               = r_valid;
    assign o_data                = r_data;
    assign o_lane_id             = r_lane_id;
    assign o_proto_err           = r_proto_err;

endmodule

// File: tb/tb_explode_unload_arbiter.sv
// Scoreboard bench for explode_unload_arbiter: per-lane expected-word queues
// plus an expected grant-order queue, popped when a word is accepted.
module tb_explode_unload_arbiter;
    import explode_pkg::*;

    localparam int N   = 4;
    localparam int NW  = 7;
    localparam int EW  = 512;
    localparam int DW  = data_w(NW, EW);
    localparam int LW  = lane_w(N);
    localparam int RND_TOTAL = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   lane_data;
    logic [N-1:0]      recv;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic [LW-1:0]     o_lane_id;
    logic              i_ready;
    logic              o_proto_err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] lane_q [N][$];
    int            order_q[$];
    int            deliv_cnt = 0;
    int            raise_cnt [N];
    bit            rnd_mode = 1'b0;
    bit            mon_en   = 1'b0;
    logic [DW-1:0] mon_exp;
    int            mon_lane;

    explode_unload_arbiter #(
        .N_LANES       (N),
        .NONCE_WIDTH   (NW),
        .EXPLODE_WIDTH (EW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_lane_handshake      (req),
        .i_lane_data           (lane_data),
        .o_lane_handshake_recv (recv),
        .o_valid               (o_valid),
        .o_data                (o_data),
        .o_lane_id             (o_lane_id),
        .i_ready               (i_ready),
        .o_proto_err           (o_proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: accepted words are checked against the scoreboard on the
    // falling edge before the accepting rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checks++;
            if ($countones(recv) > 1) begin
                failures++;
                $display("FAIL recv_onehot: recv=%b required at most one bit", recv);
            end
            checks++;
            if ((|recv) && o_valid) begin
                failures++;
                $display("FAIL recv_while_valid: recv=%b o_valid=%b required recv=0 while valid", recv, o_valid);
            end
            if (o_valid && i_ready) begin
                deliv_cnt++;
                if (order_q.size() > 0) begin
                    mon_lane = order_q.pop_front();
                    checks++;
                    if (int'(o_lane_id) !== mon_lane) begin
                        failures++;
                        $display("FAIL grant_order: lane=%0d required %0d", o_lane_id, mon_lane);
                    end
                end
                checks++;
                if (lane_q[o_lane_id].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: lane=%0d delivered with no word outstanding", o_lane_id);
                end else begin
                    mon_exp = lane_q[o_lane_id].pop_front();
                    if (o_data !== mon_exp) begin
                        failures++;
                        $display("FAIL word_data lane %0d: got %h required %h", o_lane_id, o_data, mon_exp);
                    end
                end
                if (rnd_mode) begin
                    checks++;
                    if (deliv_cnt - raise_cnt[o_lane_id] > N) begin
                        failures++;
                        $display("FAIL starvation lane %0d: waited %0d transactions, required <= %0d",
                                 o_lane_id, deliv_cnt - raise_cnt[o_lane_id], N);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) begin
            w = {w[DW-33:0], $urandom()};
        end
        return w;
    endfunction

    function automatic bit sb_pending();
        bit p;
        p = (order_q.size() != 0);
        for (int k = 0; k < N; k++) begin
            if (lane_q[k].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic raise_lane(input int k, input logic [DW-1:0] d, input bit expect_word);
        lane_data[k*DW +: DW] = d;
        req[k] = 1'b1;
        if (expect_word) lane_q[k].push_back(d);
    endtask

    // Unloader behaviour: drop req on the cycle after recv is seen.
    task automatic serve(input int n);
        repeat (n) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (req[k] && recv[k]) req[k] = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int cyc;
        cyc = 0;
        while ((sb_pending() || (|req) || (|recv) || o_valid) && cyc < budget) begin
            serve(1);
            cyc++;
        end
        checks++;
        if (sb_pending() || (|req) || (|recv) || o_valid) begin
            failures++;
            $display("FAIL %s_drain: words left=%0d req=%b recv=%b after %0d cycles, required empty",
                     name, order_q.size(), req, recv, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        for (int k = 0; k < N; k++) lane_q[k].delete();
        order_q.delete();
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = '0;
        lane_data = '0;
        i_ready   = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_valid, recv, o_lane_id, o_proto_err} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%b recv=%b id=%0d err=%b required all 0",
                     o_valid, recv, o_lane_id, o_proto_err);
        end
        checks++;
        if (o_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0", o_data);
        end
        req = '1;
        repeat (3) tick();
        checks++;
        if (o_valid !== 1'b0 || recv !== '0) begin
            failures++;
            $display("FAIL reset_hold: valid=%b recv=%b required 0 while reset held", o_valid, recv);
        end
        do_reset();
    endtask

    task automatic test_single_lane();
        logic [DW-1:0] d;
        do_reset();
        d = '0;
        d[DW-1 -: 8] = 8'h5A;
        d[300 +: 32] = 32'hDEADBEEF;
        d[7:0]       = 8'h01;
        i_ready = 1'b1;
        raise_lane(2, d, 1'b1);
        order_q.push_back(2);
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid: o_valid=%b required 0 one edge after sampling", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_lane_id !== LW'(2) || recv !== '0) begin
            failures++;
            $display("FAIL single_valid: valid=%b id=%0d recv=%b required 1/2/0000", o_valid, o_lane_id, recv);
        end
        checks++;
        if (o_data !== d) begin
            failures++;
            $display("FAIL single_data: got %h required %h", o_data, d);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || recv !== 4'b0100) begin
            failures++;
            $display("FAIL single_recv_rise: valid=%b recv=%b required 0/0100", o_valid, recv);
        end
        req[2] = 1'b0;
        tick();
        checks++;
        if (recv !== 4'b0100) begin
            failures++;
            $display("FAIL single_recv_hold: recv=%b required 0100", recv);
        end
        tick();
        checks++;
        if (recv !== 4'b0000) begin
            failures++;
            $display("FAIL single_recv_fall: recv=%b required 0000", recv);
        end
        wait_drain("single", 20);
    endtask

    task automatic test_round_robin();
        do_reset();
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            raise_lane(k, rand_word(), 1'b1);
            order_q.push_back(k);
        end
        wait_drain("rr_all", 100);
        raise_lane(0, rand_word(), 1'b1);
        raise_lane(3, rand_word(), 1'b1);
        order_q.push_back(0);
        order_q.push_back(3);
        wait_drain("rr_wrap", 60);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        int bad;
        do_reset();
        d = rand_word();
        i_ready = 1'b0;
        raise_lane(1, d, 1'b1);
        order_q.push_back(1);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_lane_id !== LW'(1) || recv !== '0 || o_data !== d) begin
                failures++;
                bad++;
                if (bad < 4) $display("FAIL bp_hold cycle %0d: valid=%b id=%0d recv=%b required 1/1/0000, data stable",
                                      i, o_valid, o_lane_id, recv);
            end
            tick();
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || recv !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release: valid=%b recv=%b required 0/0010", o_valid, recv);
        end
        wait_drain("bp", 20);
    endtask

    task automatic test_early_drop();
        do_reset();
        i_ready = 1'b1;
        checks++;
        if (o_proto_err !== 1'b0) begin
            failures++;
            $display("FAIL drop_err_init: err=%b required 0", o_proto_err);
        end
        raise_lane(1, rand_word(), 1'b0);
        tick();
        req[1] = 1'b0;
        tick();
        tick();
        checks++;
        if (o_proto_err !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_err_set: err=%b valid=%b required 1/0", o_proto_err, o_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_proto_err !== 1'b1 || o_valid !== 1'b0 || recv !== '0) begin
                failures++;
                $display("FAIL drop_quiet cycle %0d: err=%b valid=%b recv=%b required 1/0/0000",
                         i, o_proto_err, o_valid, recv);
            end
        end
        raise_lane(2, rand_word(), 1'b1);
        order_q.push_back(2);
        wait_drain("drop_next", 30);
        checks++;
        if (o_proto_err !== 1'b1) begin
            failures++;
            $display("FAIL drop_err_sticky: err=%b required 1", o_proto_err);
        end
    endtask

    task automatic test_reset_in_ack();
        logic [DW-1:0] d;
        int cyc;
        do_reset();
        d = rand_word();
        i_ready = 1'b1;
        raise_lane(3, d, 1'b1);
        order_q.push_back(3);
        cyc = 0;
        while (recv !== 4'b1000 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (recv !== 4'b1000) begin
            failures++;
            $display("FAIL ack_reach: recv=%b required 1000 within 20 cycles", recv);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (recv !== '0 || o_valid !== 1'b0 || o_proto_err !== 1'b0) begin
            failures++;
            $display("FAIL ack_reset: recv=%b valid=%b err=%b required 0/0/0", recv, o_valid, o_proto_err);
        end
        rst = 1'b0;
        lane_q[3].push_back(d);
        order_q.push_back(3);
        wait_drain("ack_redeliver", 30);
    endtask

    task automatic test_random();
        int issued;
        int cyc;
        int drop_dly [N];
        do_reset();
        issued    = 0;
        cyc       = 0;
        deliv_cnt = 0;
        rnd_mode  = 1'b1;
        for (int k = 0; k < N; k++) begin
            drop_dly[k]  = 0;
            raise_cnt[k] = 0;
        end
        while ((deliv_cnt < RND_TOTAL || (|req) || (|recv)) && cyc < 60000) begin
            tick();
            cyc++;
            i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    if (recv[k]) begin
                        if (drop_dly[k] == 0) req[k] = 1'b0;
                        else drop_dly[k]--;
                    end
                end else if (!recv[k] && issued < RND_TOTAL && $urandom_range(0, 2) == 0) begin
                    raise_lane(k, rand_word(), 1'b1);
                    raise_cnt[k] = deliv_cnt;
                    drop_dly[k]  = $urandom_range(0, 2);
                    issued++;
                end
            end
        end
        rnd_mode = 1'b0;
        checks++;
        if (deliv_cnt != RND_TOTAL || sb_pending()) begin
            failures++;
            $display("FAIL random_total: delivered %0d required %0d, outstanding=%0d",
                     deliv_cnt, RND_TOTAL, sb_pending());
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_reset_in_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
